elevator_call_scheduler: RTL
============================

# elevator_call_scheduler

Request scheduler that sits in front of `elevator_controller`. It latches cab and hall calls, decides the next floor the car should serve using a LOOK sweep policy, and hands that floor to the car controller over a valid/ready handshake. It clears served calls when the car reports arrival, and drives the call-lamp outputs.

## Interface
- `NUM_FLOORS`, default 4: number of floors served.
- `FLOOR_W`, default 2: floor index width, equal to clog2(NUM_FLOORS).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cab_req` in NUM_FLOORS: cab button per floor; pulse or level.
- `hall_up_req` in NUM_FLOORS: hall up-call per floor; the top-floor bit is ignored.
- `hall_dn_req` in NUM_FLOORS: hall down-call per floor; the bit-0 floor is ignored.
- `car_floor` in FLOOR_W: current car position from the car controller.
- `hold` in 1: overload or maintenance inhibit; blocks issuing new targets.
- `target_ready` in 1: car controller accepts a target.
- `arrive` in 1: single-cycle pulse meaning the car stopped at `car_floor` and the door opened.
- `target_valid` out 1: a target is offered.
- `target_floor` out FLOOR_W: the offered target floor.
- `dir_up` out 1: sweep direction; 1 = up.
- `busy` out 1: high in any state other than IDLE.
- `pend_cab`, `pend_up`, `pend_dn` out NUM_FLOORS each: latched calls, used as lamps.

## Operation
- **Latching:** each edge sets `pend_x <= (pend_x | x_req)`, after masking the invalid end-floor hall bits. When a set and a clear hit the same bit in the same cycle, the set wins.
- **Selection policy** (combinational, on the registered pending vectors):
  - Let `any[f] = pend_cab[f] | pend_up[f] | pend_dn[f]`.
  - If `any[car_floor]`, target = `car_floor`.
  - Else if `dir_up`: target = the lowest f > `car_floor` with `pend_cab[f] | pend_up[f]`. If there is none, target = the highest f > `car_floor` with `pend_dn[f]`.
  - Down is the mirror: the highest f < `car_floor` with `pend_cab | pend_dn`, else the lowest f < `car_floor` with `pend_up`.
  - If no candidate exists in the current direction, the policy reports "reverse".
- **FSM states:** IDLE, SELECT, DISPATCH, WAIT_ARRIVE.
  - **IDLE:** go to SELECT when `(|any) && !hold`.
  - **SELECT:**
    - Candidate found: load `target_floor` and go to DISPATCH.
    - Reverse: toggle `dir_up` and stay in SELECT for one more cycle.
    - Nothing pending: return to IDLE.
    - Second consecutive reverse: return to IDLE (defensive; unreachable when `|any`).
  - **DISPATCH:** `target_valid` = 1 and `target_floor` is held stable. On `target_valid && target_ready`, go to WAIT_ARRIVE. `hold` does not withdraw an offered target.
  - **WAIT_ARRIVE:** on `arrive`, update direction, clear calls, then go to SELECT, or to IDLE if `hold` is high. No retargeting happens while waiting.
- **Arrival update** at floor f = `car_floor`:
  - First, if `dir_up` and no `any` bit is set above f, clear `dir_up`.
  - Mirror: if down and no `any` bit is set below f, set `dir_up`.
  - Then clear `pend_cab[f]`, plus `pend_up[f]` if the new `dir_up` = 1, or `pend_dn[f]` if it = 0.
  - At f = 0 or f = NUM_FLOORS-1, clear both hall bits.
- `arrive` outside WAIT_ARRIVE is ignored.

## Timing
- **Reset values:**
  - `pend_*` = 0, `target_valid` = 0, `target_floor` = 0, `dir_up` = 1, `busy` = 0, state = IDLE.
  - Requests presented during reset are dropped.
- **Latency:**
  - A request sampled at edge 0 appears on its lamp after edge 0.
  - The FSM enters SELECT at edge 1.
  - `target_valid` rises after edge 2, i.e. 3 cycles after the request is asserted.
  - Each direction reversal adds 1 cycle.
- **Hold:** release of `hold` in IDLE with calls pending gives `target_valid` 2 cycles later.
- **Handshake:**
  - The transfer happens on the edge where both `target_valid` and `target_ready` are high.
  - `target_valid` drops on the next cycle.
  - `target_floor` may change only while `target_valid` = 0.
- **Arrival:** the pending-bit clear and the `dir_up` update are visible the cycle after `arrive`.
- **Mid-operation reset:** `rst_n` low in any state immediately forces the reset values, including `target_valid` low.

## Structure
- `elevator_pkg` holds:
  - `NUM_FLOORS` and `FLOOR_W` defaults.
  - The state enum `sched_state_t`: IDLE, SELECT, DISPATCH, WAIT_ARRIVE.
  - Direction constants `DIR_UP` and `DIR_DN`.
- One sub-module, `elevator_target_select`:
  - Purely combinational.
  - Inputs: the pending vectors, `car_floor`, `dir_up`.
  - Outputs: `found`, `sel_floor`, `reverse`.
  - The scheduler top instantiates it and owns all registers.

## Test plan
- **Reset:** assert `rst_n` = 0 with `cab_req` = 4'b1111 → all `pend_*` = 0, `target_valid` = 0, `dir_up` = 1. Release → no target issued.
- **Single call:** car at 0, `cab_req` = 4'b1000 pulsed at cycle 0 → `target_valid` = 1 with `target_floor` = 3 at cycle 3. Ready accepted. `arrive` at floor 3 → `pend_cab` = 0, `dir_up` = 0.
- **Sweep order:** car at 1 going up, `pend_cab` = 4'b1001, `pend_up[2]` = 1 → targets issued in order 2, 3, 0, with `dir_up` flipping after floor 3.
- **Top-of-sweep hall call:** car at 0, `hall_dn_req` = 4'b0100 only → target 2. On arrive, `pend_dn[2]` = 0 and `dir_up` = 0.
- **Set/clear collision:** `cab_req[2]` asserted in the same cycle as `arrive` at floor 2 → `pend_cab[2]` stays 1 and the next target is 2.
- **Handshake and hold:**
  - `target_ready` held 0 for 5 cycles → `target_valid` and `target_floor` remain stable.
  - `hold` = 1 in IDLE with calls pending → no valid. Release → valid 2 cycles later.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared defaults, state encoding and direction constants for the call scheduler
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DISPATCH,
    WAIT_ARRIVE
  } sched_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// rtl/elevator_call_scheduler_if.sv - target handshake and arrival report between scheduler and car controller
interface elevator_call_scheduler_if #(
  parameter int FLOOR_W = elevator_pkg::FLOOR_W
);

  logic               target_valid;
  logic               target_ready;
  logic [FLOOR_W-1:0] target_floor;
  logic [FLOOR_W-1:0] car_floor;
  logic               arrive;

  modport master (
    output target_valid,
    output target_floor,
    input  target_ready,
    input  car_floor,
    input  arrive
  );

  modport slave (
    input  target_valid,
    input  target_floor,
    output target_ready,
    output car_floor,
    output arrive
  );

endinterface

// File: rtl/elevator_target_select.sv
// rtl/elevator_target_select.sv - combinational LOOK policy choosing the next floor to serve
module elevator_target_select #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pend_cab,
  input  logic [NUM_FLOORS-1:0] pend_up,
  input  logic [NUM_FLOORS-1:0] pend_dn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  dir_up,
  output logic                  found,
  output logic [FLOOR_W-1:0]    sel_floor,
  output logic                  reverse
);

  logic [NUM_FLOORS-1:0] any;
  logic                  near_hit;

  always_comb begin
    any       = pend_cab | pend_up | pend_dn;
    found     = 1'b0;
    near_hit  = 1'b0;
    sel_floor = car_floor;
    if (any[car_floor]) begin
      found = 1'b1;
    end else if (dir_up) begin
      // Loop order makes the last hit the nearest same-direction call, then the farthest turn-around call.
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
        if (f > int'(car_floor) && (pend_cab[f] || pend_up[f])) begin
          near_hit  = 1'b1;
          sel_floor = FLOOR_W'(f);
        end
      end
      if (!near_hit) begin
        for (int f = 0; f < NUM_FLOORS; f++) begin
          if (f > int'(car_floor) && pend_dn[f]) begin
            near_hit  = 1'b1;
            sel_floor = FLOOR_W'(f);
          end
        end
      end
      found = near_hit;
    end else begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (f < int'(car_floor) && (pend_cab[f] || pend_dn[f])) begin
          near_hit  = 1'b1;
          sel_floor = FLOOR_W'(f);
        end
      end
      if (!near_hit) begin
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
          if (f < int'(car_floor) && pend_up[f]) begin
            near_hit  = 1'b1;
            sel_floor = FLOOR_W'(f);
          end
        end
      end
      found = near_hit;
    end
    reverse = !found && (|any);
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - latches calls, sweeps LOOK targets to the car controller, clears served calls
module elevator_call_scheduler #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] cab_req,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic                  hold,
  output logic                  dir_up,
  output logic                  busy,
  output logic [NUM_FLOORS-1:0] pend_cab,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  elevator_call_scheduler_if.master car
);

  import elevator_pkg::*;

  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  sched_state_t          state, state_nxt;
  logic                  rev_seen;
  logic                  found, reverse;
  logic [FLOOR_W-1:0]    sel_floor;
  logic [FLOOR_W-1:0]    target_floor;
  logic [NUM_FLOORS-1:0] any;
  logic [NUM_FLOORS-1:0] clr_cab, clr_up, clr_dn;
  logic                  above, below, arr_dir, arrive_hit;

  elevator_target_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_select (
    .pend_cab  (pend_cab),
    .pend_up   (pend_up),
    .pend_dn   (pend_dn),
    .car_floor (car.car_floor),
    .dir_up    (dir_up),
    .found     (found),
    .sel_floor (sel_floor),
    .reverse   (reverse)
  );

  assign any        = pend_cab | pend_up | pend_dn;
  assign arrive_hit = (state == WAIT_ARRIVE) && car.arrive;

  // Direction flips only when nothing remains ahead; the hall call matching the new direction is served.
  always_comb begin
    above   = 1'b0;
    below   = 1'b0;
    clr_cab = '0;
    clr_up  = '0;
    clr_dn  = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (f > int'(car.car_floor)) above = above | any[f];
      if (f < int'(car.car_floor)) below = below | any[f];
    end
    arr_dir = dir_up;
    if (dir_up && !above)      arr_dir = DIR_DN;
    else if (!dir_up && !below) arr_dir = DIR_UP;
    if (arrive_hit) begin
      clr_cab[car.car_floor] = 1'b1;
      if (car.car_floor == '0 || int'(car.car_floor) == NUM_FLOORS - 1) begin
        clr_up[car.car_floor] = 1'b1;
        clr_dn[car.car_floor] = 1'b1;
      end else if (arr_dir) begin
        clr_up[car.car_floor] = 1'b1;
      end else begin
        clr_dn[car.car_floor] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cab <= '0;
      pend_up  <= '0;
      pend_dn  <= '0;
    end else begin
      pend_cab <= (pend_cab & ~clr_cab) | cab_req;
      pend_up  <= (pend_up  & ~clr_up)  | (hall_up_req & UP_MASK);
      pend_dn  <= (pend_dn  & ~clr_dn)  | (hall_dn_req & DN_MASK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if ((|any) && !hold) state_nxt = SELECT;
      SELECT: begin
        if (found)                       state_nxt = DISPATCH;
        else if (!(|any) || rev_seen)    state_nxt = IDLE;
        else                             state_nxt = SELECT;
      end
      DISPATCH:    if (car.target_ready) state_nxt = WAIT_ARRIVE;
      WAIT_ARRIVE: if (car.arrive)       state_nxt = hold ? IDLE : SELECT;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_up       <= DIR_UP;
      target_floor <= '0;
      rev_seen     <= 1'b0;
    end else begin
      if (state == SELECT && reverse) begin
        if (!rev_seen) dir_up <= ~dir_up;
        rev_seen <= 1'b1;
      end else begin
        rev_seen <= 1'b0;
      end
      if (state == SELECT && found) target_floor <= sel_floor;
      if (arrive_hit)               dir_up       <= arr_dir;
    end
  end

  always_comb begin
    car.target_valid = (state == DISPATCH);
    car.target_floor = target_floor;
    busy             = (state != IDLE);
  end

endmodule
